// File: rtl/serial_bus_capture_if.sv
// serial_bus_capture_if
//   Handshake bundle between a serial producer / word consumer (master side)
//   and the serial_bus_capture stage (slave side).
//
//   data          producer -> capture   serial bit, MSB first
//   shiftEnable   producer -> capture   qualifies data, one bit per cycle
//   ack           consumer -> capture   releases the held word
//   outputEnable  consumer -> capture   bus select for the tristate output
//   ready         capture  -> consumer  held word valid
//   overrun       capture  -> consumer  sticky: a completed word was dropped
//
//   The tristate word bus itself (Q) is a plain port of the capture module,
//   because it is a shared wire rather than a point-to-point handshake.
interface serial_bus_capture_if;
  logic data;
  logic shiftEnable;
  logic ack;
  logic outputEnable;
  logic ready;
  logic overrun;

  modport master (
    output data,
    output shiftEnable,
    output ack,
    output outputEnable,
    input  ready,
    input  overrun
  );

  modport slave (
    input  data,
    input  shiftEnable,
    input  ack,
    input  outputEnable,
    output ready,
    output overrun
  );
endinterface

// File: rtl/serial_bus_capture.sv
// serial_bus_capture
//   Serial-to-parallel capture stage. Bits arrive MSB first on bus.data while
//   bus.shiftEnable is high; every WIDTH accepted bits form a word that is
//   moved into a holding register guarded by a ready/ack handshake. The shift
//   register keeps collecting while a word is held, so a second word that
//   completes before the first is acknowledged is dropped and flagged on the
//   sticky overrun output.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset (clears all state while low)
//   bus   serial_bus_capture_if.slave: data, shiftEnable, ack, outputEnable
//         in; ready, overrun out
//   Q     WIDTH-bit tristate bus: drives the held word when outputEnable and
//         ready are both high, high-Z otherwise (purely combinational)
//
// Parameters
//   WIDTH word width in bits, 2..32
module serial_bus_capture #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_bus_capture_if.slave  bus,
  output wire  [WIDTH-1:0]     Q
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_bus_capture: WIDTH must be in 2..32");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               overrun_q, overrun_d;

  // The word being completed this cycle: the shift register's low bits with
  // the incoming bit appended. Used both as the next shift value and as the
  // word handed to the holding register on completion.
  logic [WIDTH-1:0]   word_in;
  logic               wc;

  assign word_in = {sh_q[WIDTH-2:0], bus.data};
  assign wc      = bus.shiftEnable && (cnt_q == LAST_BIT);

  // ---------------------------------------------------------------------
  // Shift register and bit counter
  // ---------------------------------------------------------------------
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (bus.shiftEnable) begin
      sh_d  = word_in;
      // Explicit wrap so non-power-of-two widths restart at bit 0.
      cnt_d = wc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Holding register state machine
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    overrun_d = overrun_q;
    case (state_q)
      EMPTY: begin
        // ack is ignored here and leaves overrun untouched.
        if (wc) begin
          hold_d  = word_in;
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.ack) begin
          overrun_d = 1'b0;
          // An ack coinciding with a completion hands over directly, so the
          // consumer sees the new word without a ready gap.
          if (wc) begin
            hold_d = word_in;
          end else begin
            state_d = EMPTY;
          end
        end else if (wc) begin
          // Consumer too slow: keep the old word, drop the new one.
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      sh_q      <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ready   = (state_q == FULL);
  assign bus.overrun = overrun_q;

  // hold keeps its stale value after EMPTY but is never put on the bus then.
  assign Q = (bus.outputEnable && (state_q == FULL)) ? hold_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_serial_bus_capture.sv
// tb_serial_bus_capture
//   Directed scenarios plus a randomized stream for serial_bus_capture
//   (WIDTH = 8), checked against a word-level reference model.
module tb_serial_bus_capture;

  localparam int W = 8;

  logic          clk;
  logic          rst;
  wire [W-1:0]   Q;

  serial_bus_capture_if bus_if ();

  serial_bus_capture #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if),
    .Q   (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ------------------------------------------------------------------
  // Reference model: counts accepted bits and builds the word value
  // arithmetically (first bit has weight 2^(W-1)); the handshake rules are
  // applied at word level.
  // ------------------------------------------------------------------
  int unsigned m_nbits;
  int unsigned m_val;
  logic [W-1:0] m_hold;
  bit          m_ready;
  bit          m_ovr;

  task automatic model_reset();
    m_nbits = 0;
    m_val   = 0;
    m_hold  = '0;
    m_ready = 0;
    m_ovr   = 0;
  endtask

  task automatic model_clock(input bit d, input bit se, input bit a);
    bit wc;
    logic [W-1:0] word;
    wc   = 0;
    word = '0;
    if (se) begin
      m_val   = (m_val * 2 + d) % (1 << W);
      m_nbits = m_nbits + 1;
      if (m_nbits == W) begin
        wc      = 1;
        word    = W'(m_val);
        m_nbits = 0;
        m_val   = 0;
      end
    end
    if (m_ready && a) begin
      m_ovr = 0;
      if (wc) begin
        m_hold = word;
        $display("[%0t] word %h replaces held word on ack", $time, word);
      end else begin
        m_ready = 0;
        $display("[%0t] ack releases word %h", $time, m_hold);
      end
    end else if (wc) begin
      if (m_ready) begin
        m_ovr = 1;
        $display("[%0t] word %h dropped, %h still held", $time, word, m_hold);
      end else begin
        m_hold  = word;
        m_ready = 1;
        $display("[%0t] word %h held", $time, word);
      end
    end
  endtask

  // Drive one cycle of inputs, let the rising edge happen, update the model,
  // and return 1 time unit after the edge.
  task automatic drive_cycle(input bit d, input bit se, input bit a, input bit oe);
    bus_if.data         = d;
    bus_if.shiftEnable  = se;
    bus_if.ack          = a;
    bus_if.outputEnable = oe;
    @(posedge clk);
    model_clock(d, se, a);
    #1;
    bus_if.ack         = 1'b0;
    bus_if.shiftEnable = 1'b0;
  endtask

  // Released bus: 4-state simulators read high-Z; simulators without Z
  // resolve an undriven net to zero. All test words are nonzero, so a
  // driven bus never passes this.
  function automatic bit q_released(input logic [W-1:0] v);
    return (v === {W{1'bz}}) || (v === {W{1'b0}});
  endfunction

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    bus_if.data = 1'b0;
    bus_if.shiftEnable = 1'b0;
    bus_if.ack = 1'b0;
    bus_if.outputEnable = 1'b1;
    model_reset();
    #2;
    checks++;
    if (bus_if.ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", bus_if.ready);
    end
    checks++;
    if (bus_if.overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: got %b want 0", bus_if.overrun);
    end
    checks++;
    if (!q_released(Q)) begin
      errors++; $display("FAIL reset_q: got %h want Z", Q);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_single_word();
    logic [W-1:0] w;
    w = 8'hB2;
    for (int i = W - 1; i >= 0; i--) begin
      drive_cycle(w[i], 1'b1, 1'b0, 1'b1);
      if (i != 0) begin
        checks++;
        if (bus_if.ready !== 1'b0) begin
          errors++; $display("FAIL single_early_ready: bit %0d got %b want 0", W - 1 - i, bus_if.ready);
        end
      end
    end
    checks++;
    if (bus_if.ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b want 1", bus_if.ready);
    end
    checks++;
    if (Q !== 8'hB2) begin
      errors++; $display("FAIL single_q: got %h want b2", Q);
    end
    bus_if.outputEnable = 1'b0;
    #1;
    checks++;
    if (!q_released(Q) || bus_if.ready !== 1'b1) begin
      errors++; $display("FAIL single_oe_off: q=%h ready=%b want Z and 1", Q, bus_if.ready);
    end
    bus_if.outputEnable = 1'b1;
    #1;
    checks++;
    if (Q !== 8'hB2) begin
      errors++; $display("FAIL single_oe_on: got %h want b2", Q);
    end
  endtask

  task automatic test_handshake();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus_if.ready !== 1'b0) begin
      errors++; $display("FAIL hs_ready: got %b want 0", bus_if.ready);
    end
    checks++;
    if (!q_released(Q)) begin
      errors++; $display("FAIL hs_q: got %h want Z", Q);
    end
    checks++;
    if (bus_if.overrun !== 1'b0) begin
      errors++; $display("FAIL hs_overrun: got %b want 0", bus_if.overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] s;
    s = 16'h3CC3;
    for (int i = 2 * W - 1; i >= 0; i--) begin
      drive_cycle(s[i], 1'b1, (i == 0), 1'b1);
      if (i == W) begin
        checks++;
        if (Q !== 8'h3C || bus_if.ready !== 1'b1) begin
          errors++; $display("FAIL b2b_first: q=%h ready=%b want 3c and 1", Q, bus_if.ready);
        end
      end
    end
    checks++;
    if (Q !== 8'hC3) begin
      errors++; $display("FAIL b2b_q: got %h want c3", Q);
    end
    checks++;
    if (bus_if.ready !== 1'b1 || bus_if.overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_flags: ready=%b overrun=%b want 1 0", bus_if.ready, bus_if.overrun);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_overrun();
    logic [2*W-1:0] s;
    s = 16'h1122;
    for (int i = 2 * W - 1; i >= 0; i--) begin
      drive_cycle(s[i], 1'b1, 1'b0, 1'b1);
      if (i == 1) begin
        checks++;
        if (bus_if.overrun !== 1'b0) begin
          errors++; $display("FAIL ovr_early: got %b want 0 before 16th bit", bus_if.overrun);
        end
      end
    end
    checks++;
    if (Q !== 8'h11 || bus_if.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_set: q=%h overrun=%b want 11 and 1", Q, bus_if.overrun);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus_if.ready !== 1'b0 || bus_if.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: ready=%b overrun=%b want 0 0", bus_if.ready, bus_if.overrun);
    end
  endtask

  task automatic test_gapped();
    logic [W-1:0] w;
    w = 8'h5A;
    for (int i = W - 1; i >= 0; i--) begin
      drive_cycle(w[i], 1'b1, 1'b0, 1'b1);
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
          checks++;
          if (bus_if.ready !== 1'b0) begin
            errors++; $display("FAIL gap_ready: gap %0d got %b want 0", g, bus_if.ready);
          end
        end
      end
      if (i == 1) begin
        checks++;
        if (bus_if.ready !== 1'b0) begin
          errors++; $display("FAIL gap_7th: got %b want 0", bus_if.ready);
        end
      end
    end
    checks++;
    if (bus_if.ready !== 1'b1 || Q !== 8'h5A) begin
      errors++; $display("FAIL gap_word: ready=%b q=%h want 1 5a", bus_if.ready, Q);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] s;
    logic [W-1:0] w;
    s = 16'h7766;
    for (int i = 2 * W - 1; i >= 0; i--) drive_cycle(s[i], 1'b1, 1'b0, 1'b1);
    // Three bits of a partial word that the reset must discard.
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus_if.ready !== 1'b0 || bus_if.overrun !== 1'b0) begin
      errors++; $display("FAIL areset_flags: ready=%b overrun=%b want 0 0", bus_if.ready, bus_if.overrun);
    end
    checks++;
    if (!q_released(Q)) begin
      errors++; $display("FAIL areset_q: got %h want Z", Q);
    end
    #1 rst = 1'b1;
    w = 8'hA5;
    for (int i = W - 1; i >= 0; i--) drive_cycle(w[i], 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus_if.ready !== 1'b1 || Q !== 8'hA5) begin
      errors++; $display("FAIL areset_word: ready=%b q=%h want 1 a5", bus_if.ready, Q);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    bit d, se, a, oe;
    for (int n = 0; n < 600; n++) begin
      d  = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 9) == 0);
      oe = ($urandom_range(0, 4) != 0);
      drive_cycle(d, se, a, oe);
      checks++;
      if (bus_if.ready !== m_ready || bus_if.overrun !== m_ovr) begin
        errors++;
        $display("FAIL rand_flags: cycle %0d ready=%b overrun=%b want %b %b",
                 n, bus_if.ready, bus_if.overrun, m_ready, m_ovr);
      end
      checks++;
      if (m_ready && oe) begin
        if (Q !== m_hold) begin
          errors++; $display("FAIL rand_q: cycle %0d got %h want %h", n, Q, m_hold);
        end
      end else if (!q_released(Q)) begin
        // A zero held word driven onto the bus is indistinguishable here,
        // so only flag a nonzero value on a bus that should be released.
        errors++; $display("FAIL rand_qz: cycle %0d got %h want Z", n, Q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_handshake();
    test_back_to_back();
    test_overrun();
    test_gapped();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
